// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// Grants are same-cycle; read responses return one cycle later, aligned and extended.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned DATA_WIDTH_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rstL,
    input  logic                          if_req,
    input  logic [ADDR_WIDTH-1:0]         if_addr,
    output logic                          if_gnt,
    output logic                          if_rvalid,
    output logic [DATA_WIDTH_BYTES*8-1:0] if_rdata,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [1:0]                    d_size,
    input  logic                          d_unsigned,
    input  logic                          d_lock,
    input  logic [ADDR_WIDTH-1:0]         d_addr,
    input  logic [DATA_WIDTH_BYTES*8-1:0] d_wdata,
    output logic                          d_gnt,
    output logic                          d_err,
    output logic                          d_rvalid,
    output logic [DATA_WIDTH_BYTES*8-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH_BYTES-1:0]   mem_wenableL,
    output logic [DATA_WIDTH_BYTES*8-1:0] mem_w,
    input  logic [DATA_WIDTH_BYTES*8-1:0] mem_r
);
    localparam int unsigned LANES = DATA_WIDTH_BYTES;
    localparam int unsigned DW    = DATA_WIDTH_BYTES * 8;

    typedef enum logic [1:0] {TAG_NONE, TAG_FETCH, TAG_LOAD, TAG_STORE} tag_t;

    logic                  last_grant_d;
    logic                  lock_held;
    tag_t                  rsp_tag;
    logic [1:0]            rsp_off;
    logic [1:0]            rsp_size;
    logic                  rsp_uns;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic                  d_bad;
    logic                  d_ok;
    logic [LANES-1:0]      lane_mask;
    logic [DW-1:0]         rd_shift;
    logic [DW-1:0]         rd_ext;

    always_comb begin
        d_bad = (d_size == 2'd3)
             || ((d_size == 2'd1) && d_addr[0])
             || ((d_size == 2'd2) && (d_addr[1:0] != 2'b00));
        d_ok  = d_req && !d_bad;
    end

    // Arbitration: lock gives data exclusive ownership, otherwise round-robin on ties.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (rstL) begin
            if (lock_held) begin
                d_gnt = d_ok;
            end else begin
                if_gnt = if_req && (!d_ok || last_grant_d);
                d_gnt  = d_ok && !if_gnt;
            end
        end
    end

    assign d_err = rstL && d_req && d_bad;

    always_comb begin
        case (d_size)
            2'd0:    lane_mask = LANES'(4'b0001) << d_addr[1:0];
            2'd1:    lane_mask = LANES'(4'b0011) << d_addr[1:0];
            default: lane_mask = LANES'(4'b1111);
        endcase
    end

    // Memory drive: winner address in the grant cycle, otherwise the last address presented.
    always_comb begin
        mem_addr     = addr_q;
        mem_wenableL = '1;
        mem_w        = '0;
        if (!rstL) begin
            mem_addr = '0;
        end else if (if_gnt) begin
            mem_addr = if_addr & ~ADDR_WIDTH'(3);
        end else if (d_gnt) begin
            mem_addr = d_addr & ~ADDR_WIDTH'(3);
            if (d_we) begin
                mem_wenableL = ~lane_mask;
                mem_w        = d_wdata << {d_addr[1:0], 3'b000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstL) begin
            last_grant_d <= 1'b1;
            lock_held    <= 1'b0;
            rsp_tag      <= TAG_NONE;
            rsp_off      <= 2'b00;
            rsp_size     <= 2'b00;
            rsp_uns      <= 1'b0;
            addr_q       <= '0;
        end else begin
            rsp_tag <= TAG_NONE;
            if (if_gnt) begin
                addr_q       <= mem_addr;
                last_grant_d <= 1'b0;
                rsp_tag      <= TAG_FETCH;
            end else if (d_gnt) begin
                addr_q       <= mem_addr;
                last_grant_d <= 1'b1;
                lock_held    <= d_lock;
                rsp_tag      <= d_we ? TAG_STORE : TAG_LOAD;
                rsp_off      <= d_addr[1:0];
                rsp_size     <= d_size;
                rsp_uns      <= d_unsigned;
            end
        end
    end

    // Load return path: shift the addressed bytes down, then extend to full width.
    always_comb begin
        rd_shift = mem_r >> {rsp_off, 3'b000};
        case (rsp_size)
            2'd0:    rd_ext = rsp_uns ? {{(DW-8){1'b0}}, rd_shift[7:0]}
                                      : {{(DW-8){rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = rsp_uns ? {{(DW-16){1'b0}}, rd_shift[15:0]}
                                      : {{(DW-16){rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    assign if_rvalid = rstL && (rsp_tag == TAG_FETCH);
    assign d_rvalid  = rstL && (rsp_tag == TAG_LOAD);
    assign if_rdata  = if_rvalid ? mem_r : '0;
    assign d_rdata   = d_rvalid ? rd_ext : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rstL;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_unsigned, d_lock;
    logic [1:0]  d_size;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_err, d_rvalid;
    logic [31:0] d_rdata;
    logic [15:0] mem_addr;
    logic [3:0]  mem_wenableL;
    logic [31:0] mem_w;
    logic [31:0] mem_r = 32'h0;

    logic [31:0] ram [0:16383];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH_BYTES(4)) dut (
        .clk(clk), .rstL(rstL),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wenableL(mem_wenableL), .mem_w(mem_w), .mem_r(mem_r)
    );

    // Synchronous RAM: byte writes and registered read on the same edge.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (!mem_wenableL[k]) ram[mem_addr[15:2]][8*k +: 8] <= mem_w[8*k +: 8];
        mem_r <= ram[mem_addr[15:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic we, input logic [1:0] size, input logic uns,
                         input logic lock, input logic [15:0] addr, input logic [31:0] wdata);
        d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
        d_lock = lock; d_addr = addr; d_wdata = wdata;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [15:0] addr, input logic [31:0] exp);
        set_d(1'b0, size, uns, 1'b0, addr, 32'h0);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid"}, 32'(d_rvalid), 32'd1);
        chk({tag, "_rdata"}, d_rdata, exp);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[16'h0010 >> 2] = 32'h00500093;
        ram[16'h0040 >> 2] = 32'h80FF7F01;

        rstL = 1'b0;
        if_req = 1'b1; if_addr = 16'h0010;
        set_d(1'b0, 2'd2, 1'b0, 1'b0, 16'h0040, 32'h0);

        // Reset held two cycles with both ports requesting.
        repeat (2) begin
            tick();
            @(negedge clk);
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            chk("rst_wen", 32'(mem_wenableL), 32'hF);
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        end
        tick();
        rstL = 1'b1;

        // Contention: IF, D, IF, D with responses one cycle behind.
        @(negedge clk);
        chk("c0_if_gnt", 32'(if_gnt), 32'd1);
        chk("c0_d_gnt", 32'(d_gnt), 32'd0);
        chk("c0_addr", 32'(mem_addr), 32'h0010);
        tick();
        @(negedge clk);
        chk("c1_d_gnt", 32'(d_gnt), 32'd1);
        chk("c1_if_gnt", 32'(if_gnt), 32'd0);
        chk("c1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("c1_if_rdata", if_rdata, 32'h00500093);
        tick();
        @(negedge clk);
        chk("c2_if_gnt", 32'(if_gnt), 32'd1);
        chk("c2_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("c2_d_rdata", d_rdata, 32'h80FF7F01);
        tick();
        @(negedge clk);
        chk("c3_d_gnt", 32'(d_gnt), 32'd1);
        chk("c3_if_rvalid", 32'(if_rvalid), 32'd1);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("c4_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("c4_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("c4_no_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        tick();

        // Fetch alone.
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        chk("f_gnt", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("f_rvalid", 32'(if_rvalid), 32'd1);
        chk("f_rdata", if_rdata, 32'h00500093);
        tick();

        // Store byte to lane 2, then read the word back.
        set_d(1'b1, 2'd0, 1'b0, 1'b0, 16'h0022, 32'h000000AB);
        @(negedge clk);
        chk("sb_gnt", 32'(d_gnt), 32'd1);
        chk("sb_wen", 32'(mem_wenableL), 32'hB);
        chk("sb_lane2", 32'(mem_w[23:16]), 32'hAB);
        chk("sb_addr", 32'(mem_addr), 32'h0020);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("sb_no_rvalid", 32'(d_rvalid), 32'd0);
        do_load("lw20", 2'd2, 1'b0, 16'h0020, 32'h00AB0000);

        // Load extension.
        do_load("lb41", 2'd0, 1'b0, 16'h0041, 32'h0000007F);
        do_load("lb43", 2'd0, 1'b0, 16'h0043, 32'hFFFFFF80);
        do_load("lhu42", 2'd1, 1'b1, 16'h0042, 32'h000080FF);
        do_load("lh42", 2'd1, 1'b0, 16'h0042, 32'hFFFF80FF);

        // Misaligned word load is rejected.
        set_d(1'b0, 2'd2, 1'b0, 1'b0, 16'h0042, 32'h0);
        @(negedge clk);
        chk("mis_err", 32'(d_err), 32'd1);
        chk("mis_gnt", 32'(d_gnt), 32'd0);
        chk("mis_wen", 32'(mem_wenableL), 32'hF);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("mis_rvalid", 32'(d_rvalid), 32'd0);
        chk("mis_err_clr", 32'(d_err), 32'd0);
        tick();

        // Lock blocks fetch until an unlocked data access is granted.
        set_d(1'b0, 2'd2, 1'b0, 1'b1, 16'h0040, 32'h0);
        @(negedge clk);
        chk("lk_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lk_if_blocked", 32'(if_gnt), 32'd0);
            tick();
        end
        set_d(1'b0, 2'd2, 1'b0, 1'b0, 16'h0040, 32'h0);
        @(negedge clk);
        chk("ul_d_gnt", 32'(d_gnt), 32'd1);
        chk("ul_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("ul_if_free", 32'(if_gnt), 32'd1);
        chk("ul_d_rdata", d_rdata, 32'h80FF7F01);
        tick();
        if_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the processor's instruction-fetch port and its load/store port. It owns the RAM's address, byte write enables and write data, picks one requester per cycle, places store data on the correct byte lanes, and returns load data already shifted and sign- or zero-extended. It sits between the processor's fetch/execute sequencing and `mem`, replacing the direct address/write-enable drive from the processor.

## Interface
- ADDR_WIDTH, 16, byte address width into `mem`
- DATA_WIDTH_BYTES, 4, bytes per memory word; only 4 is supported
- clk  in  1  clock; all state updates on rising edge
- rstL  in  1  reset; synchronous, active-low, sampled on the rising edge of clk
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_WIDTH  fetch byte address; must be word aligned
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt or d_err
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- d_lock  in  1  hold the memory for the data port after this access
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data access accepted this cycle
- d_err  out  1  misaligned or illegal-size request rejected this cycle
- d_rvalid  out  1  d_rdata valid; loads only
- d_rdata  out  32  aligned, extended load data
- mem_addr  out  ADDR_WIDTH  word address to `mem`; low 2 bits always 0
- mem_wenableL  out  4 x 1  per-byte write enable, active-low
- mem_w  out  4 x 8  per-byte write data
- mem_r  in  4 x 8  per-byte read data; valid one cycle after mem_addr is presented

## Operation
- Arbitration (combinational on current-cycle inputs): only one requester -> it wins. Both requesting -> the port not granted last wins (round-robin). `last_grant` register, reset value = DATA, so fetch wins the first tie.
- Lock: if `lock_held` is set, fetch is blocked; the data port wins whenever d_req is high. `lock_held` is set when a granted data access has d_lock=1, and cleared when a granted data access has d_lock=0. With lock held and d_req low, no access occurs.
- Alignment check: half with d_addr[0]=1, word with d_addr[1:0]!=0, or d_size=3 -> d_err=1 for that cycle, no d_gnt, no memory access, lock state unchanged; the fetch port may be granted in the same cycle.
- Grant cycle: mem_addr = {winner_addr[ADDR_WIDTH-1:2], 2'b00}. Store: mem_wenableL[k]=0 for lanes k covered by (offset, size), all others 1; mem_w lane k = d_wdata byte (k - offset). Load/fetch: all mem_wenableL = 1.
- No grant: mem_wenableL all 1; mem_addr holds its last value.
- Response register: on every grant, capture {tag = fetch/load/store, offset, size, unsigned}. The next cycle, fetch tag -> if_rvalid=1, if_rdata = {mem_r[3..0]}; load tag -> d_rvalid=1, d_rdata = word >> (8*offset), masked to size and extended. Stores produce no rvalid; d_gnt is their completion.
- Back-to-back: a new grant may issue in the same cycle a response is returned (throughput 1 access/cycle).
- Reset (rstL=0 at an edge): if_gnt/d_gnt/d_err combinationally 0 while rstL=0; if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wenableL all 1, mem_w 0, last_grant=DATA, lock_held=0, response tag cleared. A response pending when reset is asserted is dropped.

## Timing
- Request to grant: 0 cycles (same cycle, combinational).
- Grant to rvalid: exactly 1 cycle; rvalid is high for exactly 1 cycle.
- Store write: committed in `mem` at the rising edge ending the grant cycle.
- Load immediately after store to the same word returns the new data (write commits before the following read).
- Max fetch wait under continuous data requests without lock: 1 cycle.

## Test plan
- Reset: hold rstL=0 two cycles with both requesting -> no grants, mem_wenableL all 1, rvalids 0; first cycle after release with both requesting -> if_gnt=1.
- Fetch alone: if_req, if_addr=0x0010, word 0x00500093 in memory -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=0x00500093.
- Contention: both requesting continuously for 4 cycles -> grants alternate IF, D, IF, D; each rvalid follows its grant by one cycle.
- Store byte: d_we=1, size=0, d_addr=0x0022, d_wdata=0x000000AB -> mem_wenableL = {1,0,1,1} (lane 2 low), mem_w[2]=0xAB; following load word of 0x0020 returns 0x00AB0000 in a zeroed word.
- Load extension: word 0x80FF7F01 at 0x0040; lb 0x0041 -> 0x0000007F; lb 0x0043 -> 0xFFFFFF80; lhu 0x0042 -> 0x000080FF; lh 0x0042 -> 0xFFFF80FF.
- Misalign and lock: lw at 0x0042 -> d_err=1, no mem write, no d_rvalid; load with d_lock=1 then 3 cycles of if_req -> if_gnt stays 0 until a data access with d_lock=0 is granted.
